// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam int unsigned DEF_PC_STEP  = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - memory, redirect and instruction delivery signals of the fetch stage
interface fetch_if #(
    parameter int ADDR_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         mem_req;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic                         mem_ack;
    logic [INSTRUCTION_WIDTH-1:0] mem_rdata;
    logic                         redirect;
    logic [ADDR_WIDTH-1:0]        redirect_addr;
    logic                         inst_valid;
    logic                         inst_ready;
    logic [INSTRUCTION_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0]        inst_pc;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ack, mem_rdata, redirect, redirect_addr, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_ack, mem_rdata, redirect, redirect_addr, inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with flush taking priority over push and pop
module fetch_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // pointers and occupancy; a flush empties the queue regardless of push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // entry storage; contents are only meaningful below the count, so no reset
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, single-outstanding memory request FSM and prefetch buffering
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int FIFO_DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(DEF_PC_STEP),
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = ADDR_WIDTH + INSTRUCTION_WIDTH;

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  r_mem_req;
    logic                  w_next_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_push;
    logic                  w_flush;
    logic                  w_pop;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_after;
    logic                  w_empty;
    logic                  w_full;
    logic [DW-1:0]         w_head;

    assign w_pop         = ~w_empty & bus.inst_ready;
    assign w_pc_inc      = r_fetch_pc + PC_STEP;
    // occupancy once this cycle's push and pop have landed; used for back-to-back credit
    assign w_count_after = w_count + CW'(1) - CW'(w_pop);

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.inst_valid = ~w_empty;
    assign bus.inst       = w_empty ? INSTRUCTION_WIDTH'(NOP) : w_head[INSTRUCTION_WIDTH-1:0];
    assign bus.inst_pc    = w_empty ? '0 : w_head[DW-1:INSTRUCTION_WIDTH];

    fetch_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_fetch_pc, bus.mem_rdata}),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // state, fetch PC and registered request outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
            r_mem_req  <= w_next_req;
            r_mem_addr <= w_next_addr;
        end
    end

    // next state: credit-gated issue, push on ack, redirect flushes and drains the stale response
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_fetch_pc;
        w_next_req   = r_mem_req;
        w_next_addr  = r_mem_addr;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.redirect) begin
                    w_flush   = 1'b1;
                    w_next_pc = bus.redirect_addr;
                end else if (!w_full) begin
                    w_next_state = ST_WAIT;
                    w_next_req   = 1'b1;
                    w_next_addr  = r_fetch_pc;
                end
            end
            ST_WAIT: begin
                if (bus.redirect) begin
                    w_flush   = 1'b1;
                    w_next_pc = bus.redirect_addr;
                    if (bus.mem_ack) begin
                        w_next_state = ST_IDLE;
                        w_next_req   = 1'b0;
                    end else begin
                        w_next_state = ST_DRAIN;
                    end
                end else if (bus.mem_ack) begin
                    w_push    = 1'b1;
                    w_next_pc = w_pc_inc;
                    if (w_count_after < CW'(FIFO_DEPTH)) begin
                        w_next_addr = w_pc_inc;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_req   = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.redirect) begin
                    w_flush   = 1'b1;
                    w_next_pc = bus.redirect_addr;
                end
                if (bus.mem_ack) begin
                    w_next_state = ST_IDLE;
                    w_next_req   = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_req   = 1'b0;
            end
        endcase
    end
endmodule
